// File: rtl/move_collector.sv
// move_collector: drains eight per-column move FIFOs into one valid/ready stream.
// Moves flagged invalid are dropped. The forwarded moves are counted.
// all_done is raised once every column has reported done and the output buffer is empty.
module move_collector #(
   parameter int NCOL = 8,
   parameter int MW   = 19,
   parameter int CW   = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [NCOL-1:0]    col_done,
   input  logic [NCOL-1:0]    col_empty,
   input  logic [NCOL*MW-1:0] col_data,
   output logic [NCOL-1:0]    col_rden,
   output logic [MW-1:0]      mv_data,
   output logic               mv_valid,
   input  logic               mv_ready,
   output logic [CW-1:0]      move_count,
   output logic               busy,
   output logic               all_done
);

   localparam int SW = (NCOL > 1) ? $clog2(NCOL) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SCAN  = 3'd1,
      READ  = 3'd2,
      CAPT  = 3'd3,
      DRAIN = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      occ_q, occ_d;
   logic [MW-1:0]   buf0_q, buf0_d;
   logic [MW-1:0]   buf1_q, buf1_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic [CW-1:0]   count_q, count_d;

   logic            found;
   logic [SW-1:0]   scan_idx;
   logic [MW-1:0]   cap_word;
   logic            pop;
   logic            push;
   logic            can_read;

   // Priority scan: the last match in a descending walk is the lowest non-empty column.
   always_comb begin
      found    = 1'b0;
      scan_idx = '0;
      for (int i = NCOL - 1; i >= 0; i--) begin
         if (!col_empty[i]) begin
            found    = 1'b1;
            scan_idx = SW'(i);
         end
      end
   end

   // Mux the read data of the sticky selected column.
   always_comb begin
      cap_word = '0;
      for (int i = 0; i < NCOL; i++) begin
         if (sel_q == SW'(i)) begin
            cap_word = col_data[i*MW +: MW];
         end
      end
   end

   assign pop      = (occ_q != 2'd0) && mv_ready;
   assign can_read = (occ_q != 2'd2) || pop;

   // Only read when a buffer slot is guaranteed free at the capture cycle.
   always_comb begin
      col_rden = '0;
      if (state_q == READ && can_read) begin
         col_rden[sel_q] = 1'b1;
      end
   end

   // Next-state logic for the collection sequence and the move counter.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      count_d = count_q;
      push    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               count_d = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (found) begin
               sel_d   = scan_idx;
               state_d = READ;
            end else if (&col_done) begin
               state_d = DRAIN;
            end
         end
         READ: begin
            if (can_read) begin
               state_d = CAPT;
            end
         end
         CAPT: begin
            if (!cap_word[MW-1]) begin
               push = 1'b1;
               if (count_q != '1) begin
                  count_d = count_q + 1'b1;
               end
            end
            state_d = col_empty[sel_q] ? SCAN : READ;
         end
         DRAIN: begin
            if (occ_q == 2'd0) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Two-entry output buffer; buf0 is always the head presented to the host.
   always_comb begin
      occ_d  = occ_q;
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) begin
               buf0_d = cap_word;
            end else begin
               buf1_d = cap_word;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               buf0_d = cap_word;
            end else begin
               buf0_d = buf1_q;
               buf1_d = cap_word;
            end
         end
         default: begin
         end
      endcase
   end

   // State registers; reset abandons any in-flight read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         occ_q   <= 2'd0;
         buf0_q  <= '0;
         buf1_q  <= '0;
         sel_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         buf0_q  <= buf0_d;
         buf1_q  <= buf1_d;
         sel_q   <= sel_d;
         count_q <= count_d;
      end
   end

   assign mv_data    = buf0_q;
   assign mv_valid   = (occ_q != 2'd0);
   assign move_count = count_q;
   assign busy       = (state_q == SCAN) || (state_q == READ) ||
                       (state_q == CAPT) || (state_q == DRAIN);
   assign all_done   = (state_q == DONE);

endmodule
